// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and committed after a fixed per-op busy delay.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_wr;
    logic [63:0]      r_pend;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_is_mul;
    logic             w_is_arith;
    logic             w_sgn;
    logic             w_div0;
    logic             w_issue;
    logic             w_commit;
    logic             w_mthi;
    logic             w_mtlo;
    logic [63:0]      w_result;

    // Two's-complement product: sign-extending to 64 bits makes the
    // truncated 64x64 product equal to the signed 32x32 product.
    function automatic logic [63:0] f_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic signed [63:0] xe;
        logic signed [63:0] ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return 64'(xe * ye);
    endfunction

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. 0x80000000/-1 falls out
    // naturally as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] f_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg_q;
        logic        neg_r;
        neg_q = sgn & (x[31] ^ y[31]);
        neg_r = sgn & x[31];
        mx    = neg_r ? (~x + 32'd1) : x;
        my    = (sgn & y[31]) ? (~y + 32'd1) : y;
        if (my == 32'd0) begin
            return 64'd0;
        end
        q = mx / my;
        r = mx % my;
        if (neg_q) q = ~q + 32'd1;
        if (neg_r) r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign w_is_mul   = (op[2:1] == 2'b00);
    assign w_is_arith = ~op[2];
    assign w_sgn      = ~op[0];
    assign w_div0     = (b == 32'd0);
    assign w_result   = w_is_mul ? f_mul(a, b, w_sgn) : f_div(a, b, w_sgn);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_arith) begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_is_mul ? MULT_LOAD : DIV_LOAD;
                    end else begin
                        w_mthi = (op == OP_MTHI);
                        w_mtlo = (op == OP_MTLO);
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_issue) begin
                r_wr <= w_is_mul | ~w_div0;
            end
        end
    end

    // Pending result is pure data; it is only consumed when r_wr gates the commit.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend <= w_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_wr) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
        end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops on each commit (busy falling) and compares.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] vis_hi = 32'd0;
    logic [31:0] vis_lo = 32'd0;
    int          m_bcnt = 0;
    logic        m_prev = 1'b0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference model straight from the arithmetic rules.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] ch,
                                          input logic [31:0] cl);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        int              ix;
        int              iy;
        int              iq;
        int              ir;
        logic [31:0]     q32;
        logic [31:0]     r32;
        case (o)
            3'd0: begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                return 64'(sx * sy);
            end
            3'd1: begin
                ux = {32'd0, x};
                uy = {32'd0, y};
                return 64'(ux * uy);
            end
            3'd2: begin
                if (y == 32'd0) return {ch, cl};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ix = x;
                iy = y;
                iq = ix / iy;
                ir = ix % iy;
                q32 = iq;
                r32 = ir;
                return {r32, q32};
            end
            3'd3: begin
                if (y == 32'd0) return {ch, cl};
                return {x % y, x / y};
            end
            default: return {ch, cl};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            m_bcnt = 0;
            m_prev = 1'b0;
        end else begin
            if (busy) begin
                m_bcnt++;
                check("hold_hi", hi, vis_hi);
                check("hold_lo", lo, vis_lo);
            end else if (m_prev) begin
                if (sb_q.size() == 0) begin
                    check("spurious_commit", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("commit_hi", hi, e.hi);
                    check("commit_lo", lo, e.lo);
                    check("busy_len", m_bcnt, e.n);
                    vis_hi = e.hi;
                    vis_lo = e.lo;
                end
                m_bcnt = 0;
            end
            m_prev = busy;
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] r;
        r    = model(o, x, y, vis_hi, vis_lo);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.n  = (o < 3'd2) ? MC : DC;
        sb_q.push_back(e);
    endtask

    // Issues one operation from IDLE and records its expected effect.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o <= 3'd3) begin
            push_exp(o, x, y);
            drive(o, x, y);
        end else begin
            drive(o, x, y);
            if (o == 3'd4) vis_hi = x;
            if (o == 3'd5) vis_lo = x;
            check("mt_busy", busy, 0);
            check("mt_hi", hi, vis_hi);
            check("mt_lo", lo, vis_lo);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("commit_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        do_op(3'd4, 32'h0000_1234, 32'd0);
        do_op(3'd5, 32'h0000_5678, 32'd0);
        do_op(3'd3, 32'hDEAD_BEEF, 32'd0);
        wait_idle();
        do_op(3'd2, 32'h0000_0007, 32'd0);
        wait_idle();

        // mtlo and a second mult while busy must both be dropped.
        do_op(3'd0, 32'h0001_0003, 32'h0000_0100);
        drive(3'd5, 32'hAAAA_AAAA, 32'd0);
        drive(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_idle();

        // Start held high across a whole run: accepted at t and again at t+N+1 only.
        push_exp(3'd0, 32'h0000_0011, 32'h0000_0022);
        push_exp(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd0;
        a     = 32'h0000_0011;
        b     = 32'h0000_0022;
        @(posedge clk);
        #1;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        repeat (MC + 1) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a divide.
        do_op(3'd4, 32'hCAFE_0001, 32'd0);
        do_op(3'd5, 32'hCAFE_0002, 32'd0);
        push_exp(3'd3, 32'd1000, 32'd7);
        drive(3'd3, 32'd1000, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb_q.delete();
        vis_hi = 32'd0;
        vis_lo = 32'd0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (DC + 4) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_hi", hi, 0);
        check("post_rst_lo", lo, 0);

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                rb = 32'hFFFF_FFFF;
                ra = 32'h8000_0000;
            end else if (sel == 2) rb = $urandom_range(1, 15);
            else rb = $urandom;
            do_op(ro, ra, rb);
            wait_idle();
        end

        @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit with HI/LO registers, sitting directly downstream of the single-cycle datapath's register-file read stage. It consumes two 32-bit operands plus an operation code issued by the datapath/control pair and produces HI/LO for `mfhi`/`mflo`. A `busy` flag tells the controller to stall any subsequent multiply/divide or HI/LO access until the result is committed.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu in cycles; must be ≥1.
- `DIV_CYCLES`, 10, busy duration of div/divu in cycles; must be ≥1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: issue strobe, sampled on a rising edge.
- `op` input 3: operation select.
  - 0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo.
  - 6 and 7 are reserved and behave as no-ops.
- `a` input 32: rs operand; dividend / multiplicand / mthi-mtlo source.
- `b` input 32: rt operand; divisor / multiplier.
- `busy` output 1: 1 while an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- Reset (`reset`=0, asynchronous): `busy`=0, `hi`=0, `lo`=0, counter=0. Any in-flight result is discarded.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, counter counts down.
- IDLE, `start`=1, op 0–3: latch `a`, `b`, `op`; compute the result into an internal 64-bit pending register; load counter with `MULT_CYCLES`-1 or `DIV_CYCLES`-1; go to RUN.
- IDLE, `start`=1, op 4/5: write `a` into `hi` (op 4) or `lo` (op 5) on that edge. Stay IDLE; `busy` never rises.
- IDLE, `start`=1, op 6/7: no effect.
- RUN: decrement counter each cycle. When the counter is 0, commit pending → `hi`/`lo` on that edge and return to IDLE.
- `start` while `busy`=1: ignored, including mthi/mtlo. Operands are not re-latched.
- `hi`/`lo` keep their old values for the whole RUN period. The only change happens at the commit edge.
- Arithmetic:
  - mult: signed 32×32 → 64; `hi`=[63:32], `lo`=[31:0].
  - multu: same split, unsigned.
  - div: signed; `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend.
  - divu: unsigned; `lo`=quotient, `hi`=remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero (div or divu with `b`=0): full `DIV_CYCLES` busy period, then commit leaves `hi`/`lo` unchanged.
- Counter width: $clog2 of max(`MULT_CYCLES`, `DIV_CYCLES`), minimum 1 bit.
- Combinational `*`, `/` and `%` are permitted. The cycle count is an architectural delay model, not an iterative algorithm.

## Timing
- Issue at edge t (`start`=1, op 0–3, `busy`=0):
  - `busy`=1 immediately after t.
  - Result commits at edge t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy`=0 and new `hi`/`lo` are visible after edge t+N.
  - `busy` is therefore high for exactly N cycles.
- A new `start` sampled at edge t+N (`busy` still 1 before that edge) is ignored. The earliest accepted reissue is edge t+N+1.
- mthi/mtlo: `hi`/`lo` updated at the sampling edge; latency 1.
- `reset` asserted mid-RUN: outputs go to 0 asynchronously, without waiting for `clk`. After release the unit is IDLE and the first edge can accept `start`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then mult with `a`=0xFFFFFFFE (-2), `b`=3 → `busy`=1 for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- multu with `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → after 5 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001; `hi`/`lo` unchanged at every earlier cycle.
- div with `a`=-7 (0xFFFFFFF9), `b`=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu with `b`=0 after mthi 0x1234 / mtlo 0x5678 → `busy` for 10 cycles, then `hi`=0x1234, `lo`=0x5678.
- Issue mult, pulse mtlo and a second mult during `busy` → both ignored, only the first result commits. Separately, drop `reset` to 0 at cycle 3 of a div → `busy`=0, `hi`=`lo`=0 asynchronously, and the pending result is never committed.
